// File: rtl/dug_pkg.sv
// Shared types and constants for the dug-tile map controller.
// Carve order: V1, H1, V2, H2 segments, then the shaft row and column.
package dug_pkg;

  localparam int MAP_W   = 32;
  localparam int MAP_H   = 24;
  localparam int SEG_LEN = 5;
  localparam int SHAFT_X = 16;
  localparam int SHAFT_Y = 9;
  localparam int TILES   = MAP_W * MAP_H;

  typedef logic [MAP_W-1:0][MAP_H-1:0] map_t;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
  } tile_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    CARVE,
    RUN
  } state_e;

  localparam logic [4:0] V1_BASE  = 5'd0;
  localparam logic [4:0] H1_BASE  = 5'(SEG_LEN);
  localparam logic [4:0] V2_BASE  = 5'(2 * SEG_LEN);
  localparam logic [4:0] H2_BASE  = 5'(3 * SEG_LEN);
  localparam logic [4:0] ROW_BASE = 5'(4 * SEG_LEN);
  localparam logic [4:0] COL_BASE = 5'(4 * SEG_LEN + 3);
  localparam logic [4:0] LAST_IDX = 5'd31;

  function automatic logic in_map(
    input logic [10:0] x,
    input logic [10:0] y
  );
    return (x < 11'(MAP_W)) && (y < 11'(MAP_H));
  endfunction

endpackage

// File: rtl/dug_rr_arb2.sv
// Two-way round-robin arbiter for dig-write requests.
// A requester whose ack is high this cycle is masked out.
module dug_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic [1:0] ack_mask_i,
  output logic [1:0] grant_o
);

  logic       ptr_q;
  logic       ptr_d;
  logic [1:0] elig;

  // Grant selection; pointer favours the side not granted last
  always_comb begin
    elig    = req_i & ~ack_mask_i & {2{en_i}};
    grant_o = 2'b00;
    ptr_d   = ptr_q;
    unique case (elig)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
    if (grant_o[0]) ptr_d = 1'b1;
    if (grant_o[1]) ptr_d = 1'b0;
  end

  // Pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dug_map_ctrl.sv
// Dug-tile map: clear, carve start tunnels, then arbitrated dig writes.
// Optional tile counter output under macro DUG_COUNT_EN.
module dug_map_ctrl
  import dug_pkg::*;
(
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Level_Start,
  input  logic [9:0]      Tunnel_X_Start,
  input  logic [9:0]      Tunnel_Y_Start,
  input  logic [9:0]      Tunnel_X_Start2,
  input  logic [9:0]      Tunnel_Y_Start2,
  input  logic [9:0]      Tunnel_X_Start3,
  input  logic [9:0]      Tunnel_Y_Start3,
  input  logic [9:0]      Tunnel_X_Start4,
  input  logic [9:0]      Tunnel_Y_Start4,
  input  logic [1:0]      Dig_Req,
  input  logic [1:0][4:0] Dig_X,
  input  logic [1:0][4:0] Dig_Y,
  output logic [1:0]      Dig_Ack,
  input  logic [4:0]      Query_X,
  input  logic [4:0]      Query_Y,
  output logic            Query_Dug,
  output logic            Map_Ready,
  output map_t            dug_state
`ifdef DUG_COUNT_EN
  ,
  output logic [9:0]      Dug_Count
`endif
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  map_t        map_q, map_d;
  logic [1:0]  ack_q;
  logic [1:0]  grant;
  logic [10:0] cx, cy;
  tile_t       dig_t;
  logic        wr_en;
  tile_t       wr_t;

  dug_rr_arb2 u_arb (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .en_i       ((state_q == RUN) && !Level_Start),
    .req_i      (Dig_Req),
    .ack_mask_i (ack_q),
    .grant_o    (grant)
  );

  // Sequencer: Level_Start always restarts CLEAR at column 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (Level_Start) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST_IDX) state_d = CARVE;
        end
        CARVE: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST_IDX) state_d = RUN;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Carve tile for the current step, 11-bit so no wrap
  always_comb begin
    cx = '0;
    cy = '0;
    unique case (1'b1)
      (cnt_q < H1_BASE): begin
        cx = {1'b0, Tunnel_X_Start};
        cy = {1'b0, Tunnel_Y_Start} + 11'(cnt_q - V1_BASE);
      end
      (cnt_q >= H1_BASE && cnt_q < V2_BASE): begin
        cx = {1'b0, Tunnel_X_Start2} + 11'(cnt_q - H1_BASE);
        cy = {1'b0, Tunnel_Y_Start2};
      end
      (cnt_q >= V2_BASE && cnt_q < H2_BASE): begin
        cx = {1'b0, Tunnel_X_Start3};
        cy = {1'b0, Tunnel_Y_Start3} + 11'(cnt_q - V2_BASE);
      end
      (cnt_q >= H2_BASE && cnt_q < ROW_BASE): begin
        cx = {1'b0, Tunnel_X_Start4} + 11'(cnt_q - H2_BASE);
        cy = {1'b0, Tunnel_Y_Start4};
      end
      (cnt_q >= ROW_BASE && cnt_q < COL_BASE): begin
        cx = 11'(SHAFT_X - 1) + 11'(cnt_q - ROW_BASE);
        cy = 11'(SHAFT_Y);
      end
      (cnt_q >= COL_BASE): begin
        cx = 11'(SHAFT_X);
        cy = 11'(SHAFT_Y - 1) - 11'(cnt_q - COL_BASE);
      end
    endcase
  end

  // Map next state: column clear, carve set, or granted dig set
  always_comb begin
    map_d = map_q;
    wr_en = 1'b0;
    wr_t  = '0;
    dig_t.x = grant[1] ? Dig_X[1] : Dig_X[0];
    dig_t.y = grant[1] ? Dig_Y[1] : Dig_Y[0];
    unique case (state_q)
      CLEAR: map_d[cnt_q] = '0;
      CARVE: begin
        wr_en = in_map(cx, cy);
        wr_t  = '{x: cx[4:0], y: cy[4:0]};
      end
      RUN: begin
        wr_en = (|grant) && in_map({6'd0, dig_t.x}, {6'd0, dig_t.y});
        wr_t  = dig_t;
      end
      default: map_d = map_q;
    endcase
    if (wr_en) map_d[wr_t.x][wr_t.y] = 1'b1;
  end

  // State, step counter, map and ack registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      map_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      map_q   <= map_d;
      ack_q   <= grant;
    end
  end

`ifdef DUG_COUNT_EN
  logic [9:0] count_q, count_d;

  // Count 0->1 transitions only, saturating at a full map
  always_comb begin
    count_d = count_q;
    if (state_q == CLEAR)
      count_d = '0;
    else if (wr_en && !map_q[wr_t.x][wr_t.y] && count_q != 10'(TILES))
      count_d = count_q + 10'd1;
  end

  // Tile counter register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign Dug_Count = count_q;
`endif

  assign Dig_Ack   = ack_q;
  assign Map_Ready = (state_q == RUN);
  assign dug_state = map_q;
  assign Query_Dug = (Query_Y < 5'(MAP_H)) ? map_q[Query_X][Query_Y] : 1'b0;

endmodule

// File: tb/tb_dug_map_ctrl.sv
// Scoreboard bench for dug_map_ctrl (DUG_COUNT_EN optional).
// Stimulus queues expected acks/ready rises; negedge monitor checks.
module tb_dug_map_ctrl;
  import dug_pkg::*;

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic            Level_Start;
  logic [9:0]      Tx1, Ty1, Tx2, Ty2, Tx3, Ty3, Tx4, Ty4;
  logic [1:0]      Dig_Req;
  logic [1:0][4:0] Dig_X;
  logic [1:0][4:0] Dig_Y;
  logic [1:0]      Dig_Ack;
  logic [4:0]      Query_X, Query_Y;
  logic            Query_Dug;
  logic            Map_Ready;
  map_t            dug_state;
`ifdef DUG_COUNT_EN
  logic [9:0]      Dug_Count;
`endif

  dug_map_ctrl dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .Level_Start     (Level_Start),
    .Tunnel_X_Start  (Tx1),
    .Tunnel_Y_Start  (Ty1),
    .Tunnel_X_Start2 (Tx2),
    .Tunnel_Y_Start2 (Ty2),
    .Tunnel_X_Start3 (Tx3),
    .Tunnel_Y_Start3 (Ty3),
    .Tunnel_X_Start4 (Tx4),
    .Tunnel_Y_Start4 (Ty4),
    .Dig_Req         (Dig_Req),
    .Dig_X           (Dig_X),
    .Dig_Y           (Dig_Y),
    .Dig_Ack         (Dig_Ack),
    .Query_X         (Query_X),
    .Query_Y         (Query_Y),
    .Query_Dug       (Query_Dug),
    .Map_Ready       (Map_Ready),
    .dug_state       (dug_state)
`ifdef DUG_COUNT_EN
    ,
    .Dug_Count       (Dug_Count)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int r;
    int x;
    int y;
    int cyc;
    int pop;
  } ack_e;

  ack_e ackq[$];
  int   rdyq[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic prev_rdy = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int popcnt();
    int n = 0;
    for (int x = 0; x < MAP_W; x++)
      for (int y = 0; y < MAP_H; y++)
        n += int'(dug_state[x][y]);
    return n;
  endfunction

  // Monitor: pops an expectation for every ack and every ready rise
  always @(negedge Clk) begin : mon
    ack_e e;
    int   rc;
    if (Reset_n) begin
      for (int i = 0; i < 2; i++) begin
        if (Dig_Ack[i]) begin
          if (ackq.size() == 0) begin
            chk("unexpected_ack", i, -1);
          end else begin
            e = ackq.pop_front();
            chk("ack_req", i, e.r);
            chk("ack_cyc", cyc, e.cyc);
            if (e.x < MAP_W && e.y < MAP_H)
              chk("ack_tile", int'(dug_state[e.x][e.y]), 1);
            chk("ack_pop", popcnt(), e.pop);
`ifdef DUG_COUNT_EN
            chk("ack_count", int'(Dug_Count), e.pop);
`endif
          end
        end
      end
      if (Map_Ready && !prev_rdy) begin
        if (rdyq.size() == 0) begin
          chk("unexpected_ready", cyc, -1);
        end else begin
          rc = rdyq.pop_front();
          chk("ready_cyc", cyc, rc);
        end
      end
    end
    prev_rdy = Map_Ready;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic set_starts(input int a, b, c, d, e, f, g, h);
    Tx1 = 10'(a); Ty1 = 10'(b);
    Tx2 = 10'(c); Ty2 = 10'(d);
    Tx3 = 10'(e); Ty3 = 10'(f);
    Tx4 = 10'(g); Ty4 = 10'(h);
  endtask

  task automatic level_start(input bit expect_rdy);
    Level_Start = 1'b1;
    if (expect_rdy) rdyq.push_back(cyc + 65);
    tick();
    Level_Start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!Map_Ready && n < 200) begin
      tick();
      n++;
    end
    if (!Map_Ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic dig(input int r, x, y, pop);
    Dig_X[r]   = 5'(x);
    Dig_Y[r]   = 5'(y);
    Dig_Req[r] = 1'b1;
    ackq.push_back('{r, x, y, cyc + 1, pop});
    tick();
    Dig_Req[r] = 1'b0;
    tick();
  endtask

  task automatic query(input string nm, input int x, y, exp);
    Query_X = 5'(x);
    Query_Y = 5'(y);
    #1;
    chk(nm, int'(Query_Dug), exp);
  endtask

  int n2;

  initial begin
    Reset_n     = 1'b1;
    Level_Start = 1'b0;
    Dig_Req     = '0;
    Dig_X       = '0;
    Dig_Y       = '0;
    Query_X     = '0;
    Query_Y     = '0;
    set_starts(0, 0, 0, 0, 0, 0, 0, 0);
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_pop", popcnt(), 0);
    chk("rst_ready", int'(Map_Ready), 0);
    chk("rst_ack", int'(Dig_Ack), 0);
    tick(2);
    Reset_n = 1'b1;
    tick();

    // Level start with the reference tunnel layout
    set_starts(4, 10, 2, 15, 25, 12, 20, 20);
    level_start(1'b1);
    wait_ready();
    chk("l1_pop", popcnt(), 32);
    chk("l1_4_14", int'(dug_state[4][14]), 1);
    chk("l1_6_15", int'(dug_state[6][15]), 1);
    chk("l1_24_20", int'(dug_state[24][20]), 1);
    chk("l1_16_0", int'(dug_state[16][0]), 1);
    chk("l1_17_9", int'(dug_state[17][9]), 1);
    chk("l1_3_10", int'(dug_state[3][10]), 0);
    query("q_4_14", 4, 14, 1);
    query("q_3_10", 3, 10, 0);
`ifdef DUG_COUNT_EN
    chk("l1_count", int'(Dug_Count), 32);
`endif

    // Contested digs, each request held through its own ack cycle
    Dig_X[0] = 5'd1; Dig_Y[0] = 5'd1;
    Dig_X[1] = 5'd2; Dig_Y[1] = 5'd2;
    Dig_Req  = 2'b11;
    ackq.push_back('{0, 1, 1, cyc + 1, 33});
    ackq.push_back('{1, 2, 2, cyc + 2, 34});
    tick(2);
    Dig_Req[0] = 1'b0;
    tick();
    Dig_Req[1] = 1'b0;
    tick(3);

    // Re-dig, fresh dig, corner tile, out-of-range row
    dig(0, 1, 1, 34);
    dig(1, 5, 5, 35);
    dig(0, 31, 23, 36);
    query("q_31_23", 31, 23, 1);
    dig(0, 31, 24, 36);
    query("q_31_24", 31, 24, 0);

    // Horizontal and vertical segments running off the map edges
    set_starts(10, 3, 30, 20, 0, 21, 28, 5);
    level_start(1'b1);
    wait_ready();
    chk("l2_pop", popcnt(), 26);
    chk("l2_30_20", int'(dug_state[30][20]), 1);
    chk("l2_31_20", int'(dug_state[31][20]), 1);
    chk("l2_0_20", int'(dug_state[0][20]), 0);
    chk("l2_0_23", int'(dug_state[0][23]), 1);
    chk("l2_31_5", int'(dug_state[31][5]), 1);
    chk("l2_0_5", int'(dug_state[0][5]), 0);
    query("q_0_23", 0, 23, 1);

    // Restart mid-carve with a dig request stalled until ready
    set_starts(4, 10, 2, 15, 25, 12, 20, 20);
    level_start(1'b0);
    Dig_X[0] = 5'd7; Dig_Y[0] = 5'd7;
    Dig_Req  = 2'b01;
    tick(39);
    n2 = cyc;
    level_start(1'b1);
    ackq.push_back('{0, 7, 7, n2 + 66, 33});
    tick(32);
    chk("restart_clear_pop", popcnt(), 0);
    wait_ready();
    tick();
    Dig_Req = 2'b00;
    tick(2);
`ifdef DUG_COUNT_EN
    chk("l3_count", int'(Dug_Count), 33);
`endif

    // Async reset while an ack is showing, between clock edges
    Dig_X[0] = 5'd8; Dig_Y[0] = 5'd8;
    Dig_Req  = 2'b01;
    tick();
    chk("pre_rst_ack", int'(Dig_Ack), 1);
    chk("pre_rst_ready", int'(Map_Ready), 1);
    #1 Reset_n = 1'b0;
    #1;
    chk("mid_rst_pop", popcnt(), 0);
    chk("mid_rst_ready", int'(Map_Ready), 0);
    chk("mid_rst_ack", int'(Dig_Ack), 0);
    Dig_Req = 2'b00;
    tick();
    Reset_n = 1'b1;
    tick(2);

    chk("ackq_left", ackq.size(), 0);
    chk("rdyq_left", rdyq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
